// File: rtl/shift_pkg.sv
// Shared mode and FSM encodings for the parametrised universal shift register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

   // Operation select encodings presented on MODE.
   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_ROL  = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_LOAD = 3'b101;
   localparam logic [2:0] M_JOHN = 3'b110;
   localparam logic [2:0] M_RSVD = 3'b111;

   // Burst controller states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } burst_state_e;

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: turns one START into CNT shift operations and reports BUSY/DONE.
// Latency: eff_mode is combinational from state; BUSY/DONE decode the registered state.
// Backpressure: none; START is only sampled in IDLE and ignored otherwise.
// Ports: clk/rst_n (sync, active-low); mode_in/start/cnt from the user;
//        eff_mode to the datapath; busy/done status.
module shift_burst_ctrl
   import shift_pkg::*;
#(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    mode_in,
   input  logic          start,
   input  logic [CW-1:0] cnt,
   output logic [2:0]    eff_mode,
   output logic          busy,
   output logic          done
);

   burst_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    mode_q, mode_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      eff_mode = M_HOLD;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               // The accepting cycle itself never touches Q.
               if (cnt != '0) begin
                  cnt_d   = cnt;
                  mode_d  = mode_in;
                  state_d = RUN;
               end else begin
                  state_d = FIN;
               end
            end else begin
               eff_mode = mode_in;
            end
         end
         RUN: begin
            eff_mode = mode_q;
            // cnt_q==1 marks the last of the CNT operations.
            if (cnt_q == CW'(1)) begin
               state_d = FIN;
            end
            cnt_d = cnt_q - CW'(1);
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= M_HOLD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == FIN);

endmodule

// File: rtl/param_shift_register.sv
// Universal shift register (shift/rotate/Johnson/load) with a counted burst engine.
// Latency: one CLK edge from effective mode to Q/SOUT.
// Backpressure: START ignored while a burst is running or finishing.
// Ports: CLK, RST_N (sync, active-low); MODE/SIN/D data controls; START/CNT burst
//        request; Q contents, SOUT registered shift-out bit, BUSY/DONE handshake.
module param_shift_register
   import shift_pkg::*;
#(
   parameter  int WIDTH = 6,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [2:0]       MODE,
   input  logic             SIN,
   input  logic [WIDTH-1:0] D,
   input  logic             START,
   input  logic [CW-1:0]    CNT,
   output logic [WIDTH-1:0] Q,
   output logic             SOUT,
   output logic             BUSY,
   output logic             DONE
);

   logic [2:0]       eff_mode;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;

   shift_burst_ctrl #(
      .CW (CW)
   ) u_ctrl (
      .clk      (CLK),
      .rst_n    (RST_N),
      .mode_in  (MODE),
      .start    (START),
      .cnt      (CNT),
      .eff_mode (eff_mode),
      .busy     (BUSY),
      .done     (DONE)
   );

   // SOUT only moves on shift/rotate/Johnson; every other mode holds it.
   always_comb begin
      q_d    = q_q;
      sout_d = sout_q;
      unique case (eff_mode)
         M_SHL: begin
            q_d    = {q_q[WIDTH-2:0], SIN};
            sout_d = q_q[WIDTH-1];
         end
         M_SHR: begin
            q_d    = {SIN, q_q[WIDTH-1:1]};
            sout_d = q_q[0];
         end
         M_ROL: begin
            q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            sout_d = q_q[WIDTH-1];
         end
         M_ROR: begin
            q_d    = {q_q[0], q_q[WIDTH-1:1]};
            sout_d = q_q[0];
         end
         M_LOAD: begin
            q_d = D;
         end
         M_JOHN: begin
            q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            sout_d = q_q[WIDTH-1];
         end
         M_HOLD, M_RSVD: begin
            q_d    = q_q;
            sout_d = sout_q;
         end
         default: begin
            q_d    = q_q;
            sout_d = sout_q;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         q_q    <= '0;
         sout_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         sout_q <= sout_d;
      end
   end

   assign Q    = q_q;
   assign SOUT = sout_q;

endmodule
